// File: rtl/pipelined_bypass_adder.sv
// Carry-bypass adder/subtractor split into STAGES pipeline stages LSB-first.
// A single advance enable moves all stages together, and a full pipeline can accept and emit in the same cycle.
module pipelined_bypass_adder #(
  parameter int N      = 32,
  parameter int BLK    = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S,
  output logic         cout,
  output logic         OF,
  output logic         ZF
);

  localparam int NB  = N / BLK;
  localparam int BPS = (NB + STAGES - 1) / STAGES;

  // One ripple block; when every bit propagates, the carry-in skips straight to the carry-out.
  function automatic logic [BLK:0] blk_add(input logic [BLK-1:0] a,
                                           input logic [BLK-1:0] b,
                                           input logic           ci);
    logic [BLK-1:0] p;
    logic [BLK-1:0] s;
    logic           c;
    p = a ^ b;
    c = ci;
    for (int i = 0; i < BLK; i++) begin
      s[i] = p[i] ^ c;
      c    = (a[i] & b[i]) | (p[i] & c);
    end
    return {((&p) ? ci : c), s};
  endfunction

  logic [N-1:0]        a_in   [STAGES];
  logic [N-1:0]        bx_in  [STAGES];
  logic [N-1:0]        sum_in [STAGES];
  logic                c_in   [STAGES];
  logic [STAGES-1:0]   vld_in;

  logic [N-1:0]        a_nx   [STAGES];
  logic [N-1:0]        bx_nx  [STAGES];
  logic [N-1:0]        sum_nx [STAGES];
  logic                c_nx   [STAGES];
  logic                of_nx;
  logic                zf_nx;

  logic [N-1:0]        a_p    [STAGES];
  logic [N-1:0]        bx_p   [STAGES];
  logic [N-1:0]        sum_p  [STAGES];
  logic                c_p    [STAGES];
  logic [STAGES-1:0]   vld_p;
  logic                of_p;
  logic                zf_p;

  logic                adv;

  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv;
  assign out_valid = vld_p[STAGES-1];
  assign S         = sum_p[STAGES-1];
  assign cout      = c_p[STAGES-1];
  assign OF        = of_p;
  assign ZF        = zf_p;

  // Stage 0 input: subtract folds into inverted B with a forced carry-in of 1.
  assign a_in[0]   = A;
  assign bx_in[0]  = sub ? ~B : B;
  assign c_in[0]   = sub | cin;
  assign sum_in[0] = '0;
  assign vld_in[0] = in_valid;

  for (genvar s = 1; s < STAGES; s++) begin : g_link
    assign a_in[s]   = a_p[s-1];
    assign bx_in[s]  = bx_p[s-1];
    assign c_in[s]   = c_p[s-1];
    assign sum_in[s] = sum_p[s-1];
    assign vld_in[s] = vld_p[s-1];
  end

  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      a_nx[s]   = a_in[s];
      bx_nx[s]  = bx_in[s];
      sum_nx[s] = sum_in[s];
      c_nx[s]   = c_in[s];
      for (int b = 0; b < NB; b++) begin
        if (b / BPS == s)
          {c_nx[s], sum_nx[s][b*BLK +: BLK]} =
            blk_add(a_in[s][b*BLK +: BLK], bx_in[s][b*BLK +: BLK], c_nx[s]);
      end
    end
    // Carry into the MSB is recovered from the aligned MSB operand and sum bits.
    of_nx = a_nx[STAGES-1][N-1] ^ bx_nx[STAGES-1][N-1] ^ sum_nx[STAGES-1][N-1]
          ^ c_nx[STAGES-1];
    zf_nx = ~|sum_nx[STAGES-1];
  end

  // Stage registers: all stages advance together or all hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p             <= '0;
      sum_p[STAGES-1]   <= '0;
      c_p[STAGES-1]     <= 1'b0;
      of_p              <= 1'b0;
      zf_p              <= 1'b0;
    end else if (adv) begin
      vld_p <= vld_in;
      for (int s = 0; s < STAGES; s++) begin
        a_p[s]   <= a_nx[s];
        bx_p[s]  <= bx_nx[s];
        sum_p[s] <= sum_nx[s];
        c_p[s]   <= c_nx[s];
      end
      of_p <= of_nx;
      zf_p <= zf_nx;
    end
  end

endmodule

// File: tb/tb_pipelined_bypass_adder.sv
// Bench for pipelined_bypass_adder: directed corner cases, randomized handshake streams,
// reset flush, and a parameter sweep across three extra instances.
module tb_pipelined_bypass_adder;

  localparam int ST   = 2;
  localparam int SW_N = 10000;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, OF, ZF;
  logic [31:0] A, B, S;

  logic        sw_iv, sw_ci, sw_sb, sw_or;
  logic [63:0] sw_a, sw_b;
  logic        a_ir, a_ov, a_co, a_of, a_zf;
  logic [15:0] a_s;
  logic        b_ir, b_ov, b_co, b_of, b_zf;
  logic [15:0] b_s;
  logic        c_ir, c_ov, c_co, c_of, c_zf;
  logic [63:0] c_s;

  logic        hv [SW_N+8];
  logic [63:0] ha [SW_N+8];
  logic [63:0] hb [SW_N+8];
  logic        hc [SW_N+8];
  logic        hs [SW_N+8];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_bypass_adder #(.N(32), .BLK(8), .STAGES(ST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .S(S),
    .cout(cout), .OF(OF), .ZF(ZF));

  pipelined_bypass_adder #(.N(16), .BLK(4), .STAGES(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(sw_iv), .in_ready(a_ir), .A(sw_a[15:0]), .B(sw_b[15:0]),
    .cin(sw_ci), .sub(sw_sb), .out_valid(a_ov), .out_ready(sw_or), .S(a_s),
    .cout(a_co), .OF(a_of), .ZF(a_zf));

  pipelined_bypass_adder #(.N(16), .BLK(4), .STAGES(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(sw_iv), .in_ready(b_ir), .A(sw_a[15:0]), .B(sw_b[15:0]),
    .cin(sw_ci), .sub(sw_sb), .out_valid(b_ov), .out_ready(sw_or), .S(b_s),
    .cout(b_co), .OF(b_of), .ZF(b_zf));

  pipelined_bypass_adder #(.N(64), .BLK(8), .STAGES(8)) dut_c (
    .clk(clk), .rst(rst), .in_valid(sw_iv), .in_ready(c_ir), .A(sw_a), .B(sw_b),
    .cin(sw_ci), .sub(sw_sb), .out_valid(c_ov), .out_ready(sw_or), .S(c_s),
    .cout(c_co), .OF(c_of), .ZF(c_zf));

  // Reference: n-bit wrap-around add/subtract; overflow from the sign rule, not from carries.
  function automatic logic [66:0] ref_op(input int n, input logic [63:0] a,
                                         input logic [63:0] b, input logic ci,
                                         input logic sb);
    logic [64:0] mask, aa, bb, full;
    logic        sa, sbb, ss;
    mask = (n == 64) ? {1'b0, {64{1'b1}}} : ((65'd1 << n) - 65'd1);
    aa   = {1'b0, a} & mask;
    bb   = sb ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
    full = aa + bb + {64'h0, (sb ? 1'b1 : ci)};
    sa   = aa[n-1];
    sbb  = bb[n-1];
    ss   = full[n-1];
    return {((sa == sbb) && (ss != sa)), ((full & mask) == 65'h0), full[n],
            full[63:0] & mask[63:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b, want 0", out_valid); end
    n_vec++; if (S !== 32'h0) begin n_err++; $display("FAIL reset_S: got %h, want 0", S); end
    n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b, want 0", cout); end
    n_vec++; if (OF !== 1'b0) begin n_err++; $display("FAIL reset_OF: got %b, want 0", OF); end
    n_vec++; if (ZF !== 1'b0) begin n_err++; $display("FAIL reset_ZF: got %b, want 0", ZF); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b, want 1", in_ready); end
    tick();
  endtask

  task automatic test_directed;
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic        tci [4];
    logic        tsb [4];
    logic [34:0] te [4];
    ta[0] = 32'hFFFFFFFF; tb[0] = 32'h0; tci[0] = 1'b1; tsb[0] = 1'b0; te[0] = {3'b011, 32'h00000000};
    ta[1] = 32'h7FFFFFFF; tb[1] = 32'h1; tci[1] = 1'b0; tsb[1] = 1'b0; te[1] = {3'b100, 32'h80000000};
    ta[2] = 32'h00000005; tb[2] = 32'h7; tci[2] = 1'b1; tsb[2] = 1'b1; te[2] = {3'b000, 32'hFFFFFFFE};
    ta[3] = 32'h80000000; tb[3] = 32'h1; tci[3] = 1'b1; tsb[3] = 1'b1; te[3] = {3'b101, 32'h7FFFFFFF};
    for (int i = 0; i < 4; i++) begin
      A = ta[i]; B = tb[i]; cin = tci[i]; sub = tsb[i];
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 1; k <= ST; k++) begin
        #1;
        n_vec++;
        if (k < ST) begin
          if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL directed%0d_early: out_valid=%b at cycle %0d, want 0", i, out_valid, k);
          end
        end else if ({out_valid, OF, ZF, cout, S} !== {1'b1, te[i]}) begin
          n_err++;
          $display("FAIL directed%0d: got vld=%b OF=%b ZF=%b cout=%b S=%h, want vld=1 OF/ZF/cout=%b S=%h",
                   i, out_valid, OF, ZF, cout, S, te[i][34:32], te[i][31:0]);
        end
        tick();
      end
    end
  endtask

  task automatic test_stream(input int nops, input int p_valid, input int p_ready);
    logic [34:0] q [$];
    logic [34:0] obs, exp_v, prev_obs;
    logic [66:0] r;
    logic        prev_stall;
    int          pushed, cyc;
    pushed = 0; cyc = 0; prev_stall = 1'b0; prev_obs = '0;
    while ((pushed < nops || q.size() > 0) && cyc < 50 * nops + 100) begin
      in_valid  = (pushed < nops) && ($urandom_range(99) < p_valid);
      A         = $urandom;
      B         = $urandom;
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ($urandom_range(99) < p_ready);
      #1;
      obs = {OF, ZF, cout, S};
      if (prev_stall) begin
        n_vec++;
        if (out_valid !== 1'b1 || obs !== prev_obs) begin
          n_err++; $display("FAIL stall_hold: vld=%b obs=%h, want vld=1 obs=%h", out_valid, obs, prev_obs);
        end
      end
      n_vec++;
      if (in_ready !== (out_ready || !out_valid)) begin
        n_err++; $display("FAIL in_ready: got %b, want %b", in_ready, (out_ready || !out_valid));
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL spurious_output: got S=%h, want no output", S);
        end else begin
          exp_v = q.pop_front();
          if (obs !== exp_v) begin
            n_err++; $display("FAIL stream_result: got %h, want %h", obs, exp_v);
          end
        end
      end
      if (in_valid && in_ready) begin
        r = ref_op(32, {32'h0, A}, {32'h0, B}, cin, sub);
        q.push_back({r[66:64], r[31:0]});
        pushed++;
      end
      prev_stall = out_valid && !out_ready;
      prev_obs   = obs;
      tick();
      cyc++;
    end
    n_vec++;
    if (pushed != nops || q.size() != 0) begin
      n_err++; $display("FAIL stream_timeout: pushed=%0d pending=%0d, want pushed=%0d pending=0", pushed, q.size(), nops);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k <= ST; k++) begin
      #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL stream_extra_output: out_valid=%b, want 0", out_valid);
      end
      tick();
    end
  endtask

  task automatic test_reset_flush;
    out_ready = 1'b0; in_valid = 1'b1;
    A = $urandom; B = $urandom; cin = 1'($urandom); sub = 1'b0;
    tick();
    A = $urandom; B = $urandom;
    tick();
    // Pipeline now holds two operations; reset collides with a fresh input transfer.
    A = $urandom; B = $urandom; out_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    n_vec++; if (S !== 32'h0) begin n_err++; $display("FAIL flush_S: got %h, want 0", S); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b, want 1", in_ready); end
    for (int k = 0; k < 2 * ST + 2; k++) begin
      if (k > 0) #1;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL flush_stale: out_valid=%b at cycle %0d after reset, want 0", out_valid, k);
      end
      tick();
    end
  endtask

  task automatic test_sweep;
    logic [67:0] e, o;
    sw_or = 1'b1; sw_iv = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int t = 0; t < SW_N + 8; t++) begin
      sw_iv = (t < SW_N) && ($urandom_range(3) != 0);
      sw_a  = {$urandom, $urandom};
      sw_b  = {$urandom, $urandom};
      sw_ci = 1'($urandom);
      sw_sb = 1'($urandom);
      hv[t] = sw_iv; ha[t] = sw_a; hb[t] = sw_b; hc[t] = sw_ci; hs[t] = sw_sb;
      #1;
      e = '0;
      if (t >= 1 && hv[t-1]) e = {1'b1, ref_op(16, ha[t-1], hb[t-1], hc[t-1], hs[t-1])};
      o = a_ov ? {1'b1, a_of, a_zf, a_co, 48'h0, a_s} : 68'h0;
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL sweep_n16_s1 t=%0d: got %h, want %h", t, o, e); end
      e = '0;
      if (t >= 4 && hv[t-4]) e = {1'b1, ref_op(16, ha[t-4], hb[t-4], hc[t-4], hs[t-4])};
      o = b_ov ? {1'b1, b_of, b_zf, b_co, 48'h0, b_s} : 68'h0;
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL sweep_n16_s4 t=%0d: got %h, want %h", t, o, e); end
      e = '0;
      if (t >= 8 && hv[t-8]) e = {1'b1, ref_op(64, ha[t-8], hb[t-8], hc[t-8], hs[t-8])};
      o = c_ov ? {1'b1, c_of, c_zf, c_co, c_s} : 68'h0;
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL sweep_n64_s8 t=%0d: got %h, want %h", t, o, e); end
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    sw_iv = 1'b0; sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sb = 1'b0; sw_or = 1'b1;
    test_reset();
    test_directed();
    test_stream(8, 100, 50);
    test_stream(300, 60, 60);
    test_stream(200, 100, 100);
    test_stream(200, 100, 20);
    test_reset_flush();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
